hazard_unit_mc: RTL and testbench

//  Next-generation pipeline hazard controller for the 5-stage RISC-V core with branch prediction.

---
 rtl/hazard_unit_mc.sv | 182 ++++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard controller for the 5-stage core: stall/flush vector, E-stage
// forwarding, predictor-error flags, multi-cycle EX busy tracking with timeout,
// post-reset flush sequencing and saturating performance counters.
module hazard_unit_mc #(
  parameter int unsigned REG_AW           = 5,
  parameter int unsigned XLEN             = 32,
  parameter int unsigned RST_FLUSH_CYCLES = 2,
  parameter int unsigned MC_TIMEOUT       = 64,
  parameter int unsigned CNT_W            = 32
) (
  input  logic              clk,
  input  logic              CpuRst,
  input  logic              ICacheMiss,
  input  logic              DCacheMiss,
  input  logic              BranchE,
  input  logic              JalrE,
  input  logic              JalD,
  input  logic              PredE,
  input  logic [XLEN-1:0]   NPC_PredE,
  input  logic [XLEN-1:0]   BrNPC,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        RegReadE,
  input  logic              MemToRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MultiCycE,
  input  logic              MultiCycDone,
  output logic              StallF,
  output logic              FlushF,
  output logic              StallD,
  output logic              FlushD,
  output logic              StallE,
  output logic              FlushE,
  output logic              StallM,
  output logic              FlushM,
  output logic              StallW,
  output logic              FlushW,
  output logic [1:0]        Forward1E,
  output logic [1:0]        Forward2E,
  output logic [1:0]        Pred_Error,
  output logic              McTimeout,
  output logic [CNT_W-1:0]  PredErrCnt,
  output logic [CNT_W-1:0]  StallCycCnt
);

  localparam int unsigned RF_W    = (RST_FLUSH_CYCLES > 2) ? $clog2(RST_FLUSH_CYCLES) : 1;
  localparam int unsigned RF_LAST = (RST_FLUSH_CYCLES == 0) ? 0 : RST_FLUSH_CYCLES - 1;
  localparam int unsigned MC_W    = $clog2(MC_TIMEOUT);
  localparam int unsigned MC_LAST = MC_TIMEOUT - 1;

  // Vector order: {StallF,FlushF,StallD,FlushD,StallE,FlushE,StallM,FlushM,StallW,FlushW}
  localparam logic [9:0] V_FLUSH_ALL = 10'b0101010101;
  localparam logic [9:0] V_STALL_ALL = 10'b1010101010;
  localparam logic [9:0] V_MC_STALL  = 10'b1010100100;
  localparam logic [9:0] V_REDIRECT  = 10'b0001010000;
  localparam logic [9:0] V_LOAD_USE  = 10'b1010010000;
  localparam logic [9:0] V_JAL_D     = 10'b0001000000;

  typedef enum logic [1:0] {S_RST_FLUSH, S_IDLE, S_MC_BUSY} state_e;

  state_e           state_q, state_d;
  logic [RF_W-1:0]  rf_cnt_q, rf_cnt_d;
  logic [MC_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] pred_cnt_q, stall_cnt_q;

  logic [9:0] vec_c;
  logic [1:0] pred_err_c;
  logic       pred_hit_c;
  logic       cache_miss_c;
  logic       mc_stall_c;
  logic       mc_expired_c;
  logic       load_use_c;

  // Predictor error flags, independent of reset and FSM state
  always_comb begin
    pred_err_c[0] = BranchE & (~PredE | (NPC_PredE != BrNPC));
    pred_err_c[1] = ~BranchE & PredE;
  end

  // Hazard qualifiers
  always_comb begin
    cache_miss_c = ICacheMiss | DCacheMiss;
    mc_stall_c   = ((state_q == S_IDLE) & MultiCycE & ~MultiCycDone) |
                   ((state_q == S_MC_BUSY) & ~MultiCycDone);
    mc_expired_c = (state_q == S_MC_BUSY) & ~MultiCycDone & (mc_cnt_q == MC_W'(MC_LAST));
    load_use_c   = MemToRegE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
  end

  // Next-state and stall/flush vector selection
  always_comb begin
    state_d    = state_q;
    rf_cnt_d   = rf_cnt_q;
    mc_cnt_d   = mc_cnt_q;
    timeout_d  = timeout_q;
    vec_c      = '0;
    pred_hit_c = 1'b0;

    if (CpuRst) begin
      vec_c     = V_FLUSH_ALL;
      state_d   = (RST_FLUSH_CYCLES == 0) ? S_IDLE : S_RST_FLUSH;
      rf_cnt_d  = '0;
      mc_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (state_q == S_RST_FLUSH) begin
      vec_c = V_FLUSH_ALL;
      if (rf_cnt_q == RF_W'(RF_LAST)) state_d = S_IDLE;
      else                            rf_cnt_d = rf_cnt_q + RF_W'(1);
    end else begin
      // Busy counter keeps running through cache misses; it parks at the limit
      if ((state_q == S_MC_BUSY) && (mc_cnt_q != MC_W'(MC_LAST))) mc_cnt_d = mc_cnt_q + MC_W'(1);

      if (cache_miss_c) begin
        vec_c = V_STALL_ALL;
      end else if (mc_expired_c) begin
        vec_c     = V_REDIRECT;
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end else if (mc_stall_c) begin
        vec_c = V_MC_STALL;
        if (state_q == S_IDLE) begin
          state_d  = S_MC_BUSY;
          mc_cnt_d = '0;
        end
      end else begin
        state_d = S_IDLE;
        if ((|pred_err_c) | JalrE) begin
          vec_c      = V_REDIRECT;
          pred_hit_c = |pred_err_c;
        end else if (load_use_c) begin
          vec_c = V_LOAD_USE;
        end else if (JalD) begin
          vec_c = V_JAL_D;
        end
      end
    end
  end

  // State, sequencer counters and sticky timeout flag
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    rf_cnt_q  <= rf_cnt_d;
    mc_cnt_q  <= mc_cnt_d;
    timeout_q <= timeout_d;
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (CpuRst) begin
      pred_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pred_hit_c && (pred_cnt_q != '1)) pred_cnt_q <= pred_cnt_q + CNT_W'(1);
      if (vec_c[9] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // E-stage forwarding; M has priority over W, x0 never forwarded
  always_comb begin
    Forward1E = 2'b00;
    Forward2E = 2'b00;
    if (!CpuRst) begin
      if (RegWriteM & RegReadE[1] & (RdM == Rs1E) & (RdM != '0))      Forward1E = 2'b10;
      else if (RegWriteW & RegReadE[1] & (RdW == Rs1E) & (RdW != '0)) Forward1E = 2'b01;
      if (RegWriteM & RegReadE[0] & (RdM == Rs2E) & (RdM != '0))      Forward2E = 2'b10;
      else if (RegWriteW & RegReadE[0] & (RdW == Rs2E) & (RdW != '0)) Forward2E = 2'b01;
    end
  end

  assign {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW} = vec_c;
  assign Pred_Error  = pred_err_c;
  assign McTimeout   = timeout_q;
  assign PredErrCnt  = pred_cnt_q;
  assign StallCycCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed testbench for hazard_unit_mc (small counters and timeout for reach).
module tb_hazard_unit_mc;

  logic        clk = 1'b0;
  logic        CpuRst, ICacheMiss, DCacheMiss, BranchE, JalrE, JalD, PredE;
  logic [31:0] NPC_PredE, BrNPC;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  RegReadE;
  logic        MemToRegE, RegWriteM, RegWriteW, MultiCycE, MultiCycDone;
  logic        StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW;
  logic [1:0]  Forward1E, Forward2E, Pred_Error;
  logic        McTimeout;
  logic [3:0]  PredErrCnt, StallCycCnt;
  logic [9:0]  v;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign v = {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW};

  hazard_unit_mc #(
    .REG_AW(5), .XLEN(32), .RST_FLUSH_CYCLES(2), .MC_TIMEOUT(8), .CNT_W(4)
  ) dut (
    .clk(clk), .CpuRst(CpuRst), .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD), .PredE(PredE),
    .NPC_PredE(NPC_PredE), .BrNPC(BrNPC),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegReadE(RegReadE), .MemToRegE(MemToRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MultiCycE(MultiCycE), .MultiCycDone(MultiCycDone),
    .StallF(StallF), .FlushF(FlushF), .StallD(StallD), .FlushD(FlushD),
    .StallE(StallE), .FlushE(FlushE), .StallM(StallM), .FlushM(FlushM),
    .StallW(StallW), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .Pred_Error(Pred_Error),
    .McTimeout(McTimeout), .PredErrCnt(PredErrCnt), .StallCycCnt(StallCycCnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    ICacheMiss = 0; DCacheMiss = 0; BranchE = 0; JalrE = 0; JalD = 0; PredE = 0;
    NPC_PredE = '0; BrNPC = '0;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegReadE = '0; MemToRegE = 0; RegWriteM = 0; RegWriteW = 0;
    MultiCycE = 0; MultiCycDone = 0;
  endtask

  initial begin
    idle_inputs();
    // Reset with a forwarding match present: outputs must still be the reset values
    CpuRst = 1; RdM = 5'd7; Rs1E = 5'd7; RegWriteM = 1; RegReadE = 2'b10;
    #2;
    check("rst_vec", 32'(v), 32'h155);
    check("rst_fwd1", 32'(Forward1E), 32'h0);
    tick(); tick(); tick();
    settle();
    check("rst_predcnt", 32'(PredErrCnt), 32'd0);
    check("rst_stallcnt", 32'(StallCycCnt), 32'd0);
    check("rst_mcto", 32'(McTimeout), 32'd0);

    // Release: two flush cycles, then quiet
    CpuRst = 0; idle_inputs();
    settle(); check("rflush_c1", 32'(v), 32'h155);
    tick(); settle(); check("rflush_c2", 32'(v), 32'h155);
    tick(); settle(); check("rflush_done", 32'(v), 32'h000);

    // Multi-cycle op completing on its fourth cycle
    MultiCycE = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); check($sformatf("mc_stall_%0d", i), 32'(v), 32'h2A4);
      tick();
    end
    MultiCycDone = 1;
    settle(); check("mc_done_vec", 32'(v), 32'h000);
    tick();
    MultiCycE = 0; MultiCycDone = 0;
    settle();
    check("mc_stallcnt", 32'(StallCycCnt), 32'd3);
    check("mc_idle_vec", 32'(v), 32'h000);
    tick();

    // Multi-cycle op that never completes: timeout on the 8th busy cycle
    MultiCycE = 1;
    settle(); check("to_entry", 32'(v), 32'h2A4);
    for (int i = 1; i < 8; i++) begin
      tick(); settle(); check($sformatf("to_busy_%0d", i), 32'(v), 32'h2A4);
    end
    tick(); settle();
    check("to_abort_vec", 32'(v), 32'h050);
    check("to_not_yet", 32'(McTimeout), 32'd0);
    tick();
    MultiCycE = 0;
    settle();
    check("to_sticky1", 32'(McTimeout), 32'd1);
    check("to_after_vec", 32'(v), 32'h000);
    tick(); tick(); settle();
    check("to_sticky2", 32'(McTimeout), 32'd1);
    check("to_stallcnt", 32'(StallCycCnt), 32'd11);

    // Target mispredict on a taken branch
    BranchE = 1; PredE = 1; NPC_PredE = 32'h100; BrNPC = 32'h104;
    settle();
    check("mp_err", 32'(Pred_Error), 32'h1);
    check("mp_vec", 32'(v), 32'h050);
    tick();
    // Predicted taken, actually not taken
    BranchE = 0;
    settle();
    check("mp_cnt1", 32'(PredErrCnt), 32'd1);
    check("nt_err", 32'(Pred_Error), 32'h2);
    check("nt_vec", 32'(v), 32'h050);
    tick();
    // Correct prediction, then a jalr (flush without error count)
    BranchE = 1; BrNPC = 32'h100;
    settle();
    check("ok_err", 32'(Pred_Error), 32'h0);
    check("ok_vec", 32'(v), 32'h000);
    tick();
    idle_inputs(); JalrE = 1;
    settle(); check("jalr_vec", 32'(v), 32'h050);
    tick();
    JalrE = 0;
    settle(); check("mp_cnt2", 32'(PredErrCnt), 32'd2);

    // Load-use detection, x0-safe, and cache-miss override
    MemToRegE = 1; RdE = 5'd0; Rs1D = 5'd0;
    settle(); check("lu_x0", 32'(v), 32'h000);
    tick();
    RdE = 5'd5; Rs2D = 5'd5;
    settle(); check("lu_hit", 32'(v), 32'h290);
    tick();
    DCacheMiss = 1;
    settle(); check("lu_dmiss", 32'(v), 32'h2AA);
    tick();
    idle_inputs(); JalD = 1;
    settle(); check("jald_vec", 32'(v), 32'h040);
    tick();
    JalD = 0;
    settle(); check("lu_stallcnt", 32'(StallCycCnt), 32'd13);

    // Forwarding: M beats W; x0 in M falls back to W
    RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; RegWriteM = 1; RegWriteW = 1; RegReadE = 2'b10;
    settle();
    check("fwd1_m", 32'(Forward1E), 32'h2);
    check("fwd2_none", 32'(Forward2E), 32'h0);
    RdM = 5'd0;
    #1; check("fwd1_w", 32'(Forward1E), 32'h1);
    RegReadE = 2'b01; Rs2E = 5'd9; RdW = 5'd9;
    #1;
    check("fwd2_w", 32'(Forward2E), 32'h1);
    check("fwd1_unused", 32'(Forward1E), 32'h0);
    RdM = 5'd9;
    #1; check("fwd2_m", 32'(Forward2E), 32'h2);
    tick();

    // Stall counter saturates at 15 with CNT_W=4
    idle_inputs(); ICacheMiss = 1;
    for (int i = 0; i < 5; i++) tick();
    settle(); check("sat_15", 32'(StallCycCnt), 32'd15);
    tick(); settle(); check("sat_hold", 32'(StallCycCnt), 32'd15);
    ICacheMiss = 0;
    tick();

    // Reset during a busy op clears everything, no timeout flag
    MultiCycE = 1;
    tick(); tick();
    CpuRst = 1;
    settle(); check("rst_mid_vec", 32'(v), 32'h155);
    tick();
    CpuRst = 0; MultiCycE = 0;
    settle();
    check("rst_mid_mcto", 32'(McTimeout), 32'd0);
    check("rst_mid_stallcnt", 32'(StallCycCnt), 32'd0);
    check("rst_mid_predcnt", 32'(PredErrCnt), 32'd0);
    check("rst_mid_flush", 32'(v), 32'h155);
    tick(); tick(); settle();
    check("rst_mid_idle", 32'(v), 32'h000);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
